eth_frame_builder: RTL and testbench

- Upstream neighbour of the RMII frame transmitter; fills that transmitter's shared 2K×8 packet RAM, then kicks the transmission.
- Per frame: writes the 14-byte Ethernet header (destination MAC, source MAC, EtherType), streams payload bytes, and zero-pads to the 60-byte minimum.
- Presents the frame byte count, starts the transmitter, and holds off new payload until the transmitter reports idle.
- Single packet buffer: one frame in flight.

---
 rtl/eth_frame_builder.sv | 223 ++++++++++++++++++++++
 tb/tb_eth_frame_builder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_frame_builder.sv
// Ethernet frame builder: fills the transmitter's packet RAM with header, payload and
// zero padding, then kicks the transmitter and waits for it to return idle.
module eth_frame_builder #(
  parameter logic [47:0] MAC_DST   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] MAC_SRC   = 48'h0002_0304_0506,
  parameter logic [15:0] ETHERTYPE = 16'h0800,
  parameter logic [10:0] FRAME_MAX = 11'd1500,
  parameter logic [10:0] FRAME_MIN = 11'd60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pl_valid,
  input  logic [7:0]  i_pl_data,
  input  logic        i_pl_last,
  output logic        o_pl_ready,
  output logic        o_ram_we,
  output logic [10:0] o_ram_adr,
  output logic [7:0]  o_ram_wdata,
  output logic [10:0] o_ram_data_size,
  output logic        o_tx_en,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_err_oversize,
  output logic [15:0] o_frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_PAD,
    S_DROP,
    S_KICK,
    S_WAIT_DONE
  } state_t;

  localparam logic [111:0] HDR_BITS = {MAC_DST, MAC_SRC, ETHERTYPE};
  localparam logic [10:0]  HDR_LAST = 11'd13;
  localparam logic [10:0]  HDR_LEN  = 11'd14;

  state_t      r_state;
  logic [10:0] r_wptr;
  logic        r_ram_we;
  logic [10:0] r_ram_adr;
  logic [7:0]  r_ram_wdata;
  logic [10:0] r_data_size;
  logic        r_tx_en;
  logic        r_pl_ready;
  logic        r_busy;
  logic        r_err;
  logic [15:0] r_frames_sent;

  state_t      w_state_next;
  logic [10:0] w_wptr_next;
  logic        w_we_next;
  logic [10:0] w_adr_next;
  logic [7:0]  w_wdata_next;
  logic [10:0] w_size_next;
  logic        w_tx_en_next;
  logic        w_pl_ready_next;
  logic        w_busy_next;
  logic        w_err_next;
  logic [15:0] w_frames_next;

  logic        w_accept;
  logic [10:0] w_wptr_inc;
  logic [7:0]  w_hdr [16];

  // Header bytes in wire order, MSB byte of each field first; slots 14/15 are never addressed.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_hdr
      if (gi < 14) begin : g_byte
        assign w_hdr[gi] = HDR_BITS[111 - 8*gi -: 8];
      end else begin : g_unused
        assign w_hdr[gi] = 8'h00;
      end
    end
  endgenerate

  assign w_accept   = i_pl_valid & r_pl_ready;
  assign w_wptr_inc = r_wptr + 11'd1;

  always_comb begin
    w_state_next  = r_state;
    w_wptr_next   = r_wptr;
    w_we_next     = 1'b0;
    w_adr_next    = r_ram_adr;
    w_wdata_next  = r_ram_wdata;
    w_size_next   = r_data_size;
    w_tx_en_next  = 1'b0;
    w_err_next    = 1'b0;
    w_frames_next = r_frames_sent;

    case (r_state)
      S_IDLE: begin
        if (i_pl_valid) begin
          w_state_next = S_HDR;
          w_wptr_next  = 11'd0;
        end
      end

      S_HDR: begin
        w_we_next    = 1'b1;
        w_adr_next   = r_wptr;
        w_wdata_next = w_hdr[r_wptr[3:0]];
        if (r_wptr == HDR_LAST) begin
          w_state_next = S_PAYLOAD;
          w_wptr_next  = HDR_LEN;
        end else begin
          w_wptr_next = w_wptr_inc;
        end
      end

      S_PAYLOAD: begin
        if (w_accept) begin
          if (r_wptr < FRAME_MAX) begin
            w_we_next    = 1'b1;
            w_adr_next   = r_wptr;
            w_wdata_next = i_pl_data;
            w_wptr_next  = w_wptr_inc;
            if (i_pl_last) begin
              if (w_wptr_inc < FRAME_MIN) begin
                w_state_next = S_PAD;
              end else begin
                w_state_next = S_KICK;
                w_size_next  = w_wptr_inc;
                w_tx_en_next = 1'b1;
              end
            end
          end else if (i_pl_last) begin
            // Overflowing beat is also the last one: nothing left to discard.
            w_err_next   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_DROP;
          end
        end
      end

      S_PAD: begin
        w_we_next    = 1'b1;
        w_adr_next   = r_wptr;
        w_wdata_next = 8'h00;
        if (r_wptr == FRAME_MIN - 11'd1) begin
          w_state_next = S_KICK;
          w_size_next  = FRAME_MIN;
          w_tx_en_next = 1'b1;
        end else begin
          w_wptr_next = w_wptr_inc;
        end
      end

      S_DROP: begin
        if (w_accept && i_pl_last) begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end
      end

      S_KICK: begin
        // The request stays up until the transmitter is seen busy.
        w_tx_en_next = i_tx_ready;
        if (!i_tx_ready) begin
          w_state_next = S_WAIT_DONE;
        end
      end

      S_WAIT_DONE: begin
        if (i_tx_ready) begin
          w_frames_next = r_frames_sent + 16'd1;
          w_state_next  = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    w_pl_ready_next = (w_state_next == S_PAYLOAD) || (w_state_next == S_DROP);
    w_busy_next     = (w_state_next != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_wptr        <= 11'd0;
      r_ram_we      <= 1'b0;
      r_ram_adr     <= 11'd0;
      r_ram_wdata   <= 8'h00;
      r_data_size   <= 11'd0;
      r_tx_en       <= 1'b0;
      r_pl_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_frames_sent <= 16'd0;
    end else begin
      r_state       <= w_state_next;
      r_wptr        <= w_wptr_next;
      r_ram_we      <= w_we_next;
      r_ram_adr     <= w_adr_next;
      r_ram_wdata   <= w_wdata_next;
      r_data_size   <= w_size_next;
      r_tx_en       <= w_tx_en_next;
      r_pl_ready    <= w_pl_ready_next;
      r_busy        <= w_busy_next;
      r_err         <= w_err_next;
      r_frames_sent <= w_frames_next;
    end
  end

  assign o_pl_ready      = r_pl_ready;
  assign o_ram_we        = r_ram_we;
  assign o_ram_adr       = r_ram_adr;
  assign o_ram_wdata     = r_ram_wdata;
  assign o_ram_data_size = r_data_size;
  assign o_tx_en         = r_tx_en;
  assign o_busy          = r_busy;
  assign o_err_oversize  = r_err;
  assign o_frames_sent   = r_frames_sent;

endmodule

// File: tb/tb_eth_frame_builder.sv
// Scoreboard bench for eth_frame_builder: a packet RAM model and a transmitter model
// check every kicked frame's size and contents, drop pulses and handshake timing.
`timescale 1ns/1ps
module tb_eth_frame_builder;

  logic        i_clk;
  logic        i_rst;
  logic        i_pl_valid;
  logic [7:0]  i_pl_data;
  logic        i_pl_last;
  logic        o_pl_ready;
  logic        o_ram_we;
  logic [10:0] o_ram_adr;
  logic [7:0]  o_ram_wdata;
  logic [10:0] o_ram_data_size;
  logic        o_tx_en;
  logic        i_tx_ready;
  logic        o_busy;
  logic        o_err_oversize;
  logic [15:0] o_frames_sent;

  eth_frame_builder dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_pl_valid     (i_pl_valid),
    .i_pl_data      (i_pl_data),
    .i_pl_last      (i_pl_last),
    .o_pl_ready     (o_pl_ready),
    .o_ram_we       (o_ram_we),
    .o_ram_adr      (o_ram_adr),
    .o_ram_wdata    (o_ram_wdata),
    .o_ram_data_size(o_ram_data_size),
    .o_tx_en        (o_tx_en),
    .i_tx_ready     (i_tx_ready),
    .o_busy         (o_busy),
    .o_err_oversize (o_err_oversize),
    .o_frames_sent  (o_frames_sent)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  wire [50:0] w_outs = {o_ram_we, o_ram_adr, o_ram_wdata, o_ram_data_size, o_tx_en,
                        o_pl_ready, o_busy, o_err_oversize, o_frames_sent};

  // Packet RAM model: writes land on the edge where o_ram_we is high.
  logic [7:0] ram [2048];
  int wr_hi = 0;
  always @(posedge i_clk) begin
    if (o_ram_we) begin
      ram[o_ram_adr] <= o_ram_wdata;
      if (o_ram_adr >= 11'd1500) wr_hi <= wr_hi + 1;
    end
  end

  int   tx_rises = 0;
  logic tx_prev  = 1'b0;
  always @(negedge i_clk) begin
    tx_prev <= o_tx_en;
    if (o_tx_en && !tx_prev) tx_rises <= tx_rises + 1;
  end

  // Transmitter model: goes busy tx_delay cycles after a request, idle tx_busy cycles later.
  int tx_delay = 2;
  int tx_busy  = 8;
  initial begin : tx_model
    i_tx_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      if (o_tx_en) begin
        repeat (tx_delay) @(negedge i_clk);
        i_tx_ready = 1'b0;
        repeat (tx_busy) @(negedge i_clk);
        i_tx_ready = 1'b1;
      end
    end
  end

  int         exp_q[$];
  logic [7:0] exp_mem [2048];
  logic [7:0] pl_buf  [2048];
  int         exp_sent = 0;
  bit         mon_busy = 1'b0;
  int         n_err    = 0;

  initial begin : kick_mon
    int hi, viol, sz, cnt, e;
    forever begin
      @(negedge i_clk);
      if (o_tx_en) begin
        mon_busy = 1'b1;
        sz   = int'(o_ram_data_size);
        hi   = 0;
        viol = 0;
        if (exp_q.size() == 0) begin
          check("kick_unexpected", 64'd1, 64'd0);
          e = 0;
        end else begin
          e = exp_q.pop_front();
        end
        check("size", 64'(sz), 64'(e));
        while (o_tx_en && hi < 200) begin
          hi++;
          if (o_pl_ready || (int'(o_ram_data_size) != sz)) viol++;
          @(negedge i_clk);
        end
        check("tx_en_cycles", 64'(hi), 64'(tx_delay + 1));
        for (int a = 0; a < sz; a++) begin
          check($sformatf("ram[%0d]", a), 64'(ram[a]), 64'(exp_mem[a]));
        end
        cnt = 0;
        while (o_busy && cnt < 200) begin
          cnt++;
          if (o_pl_ready || o_ram_we || o_tx_en || (int'(o_ram_data_size) != sz)) viol++;
          @(negedge i_clk);
        end
        exp_sent++;
        check("frames_sent", 64'(o_frames_sent), 64'(exp_sent));
        check("kick_hold", 64'(viol), 64'd0);
        $display("[TB] frame kicked: size=%0d tx_en_cycles=%0d frames_sent=%0d", sz, hi, o_frames_sent);
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : drop_mon
    int e;
    forever begin
      @(negedge i_clk);
      if (o_err_oversize) begin
        n_err++;
        if (exp_q.size() == 0) e = 0;
        else e = exp_q.pop_front();
        check("drop_event", 64'(-1), 64'(e));
        @(negedge i_clk);
        check("err_pulse_width", 64'(o_err_oversize), 64'd0);
        $display("[TB] frame dropped as oversize");
      end
    end
  end

  task automatic fill_expected(input int len);
    int sz;
    sz = (14 + len < 60) ? 60 : 14 + len;
    for (int k = 0; k < 6; k++) exp_mem[k] = 8'hFF;
    exp_mem[6]  = 8'h00; exp_mem[7]  = 8'h02; exp_mem[8]  = 8'h03;
    exp_mem[9]  = 8'h04; exp_mem[10] = 8'h05; exp_mem[11] = 8'h06;
    exp_mem[12] = 8'h08; exp_mem[13] = 8'h00;
    for (int k = 0; k < len; k++) exp_mem[14 + k] = pl_buf[k];
    for (int k = 14 + len; k < sz; k++) exp_mem[k] = 8'h00;
    exp_q.push_back(sz);
  endtask

  // Drive one frame; abort_at >= 0 asserts reset once that many beats are accepted.
  task automatic send_frame(input int len, input int gap_pct, input int abort_at,
                            input int base, input bit rnd);
    int  i, cyc;
    bit  v, r;
    for (int k = 0; k < len; k++) pl_buf[k] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + k);
    if (abort_at < 0) begin
      if (14 + len > 1500) exp_q.push_back(-1);
      else fill_expected(len);
    end
    i = 0;
    cyc = 0;
    @(negedge i_clk);
    while (i < len && cyc < 20000) begin
      v = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
      i_pl_valid = v;
      i_pl_data  = pl_buf[i];
      i_pl_last  = (i == len - 1);
      r = o_pl_ready;
      @(negedge i_clk);
      cyc++;
      if (v && r) begin
        i++;
        if (i == abort_at) begin
          i_pl_valid = 1'b0;
          i_pl_last  = 1'b0;
          i_rst      = 1'b1;
          @(negedge i_clk);
          check("abort_outs", 64'(w_outs), 64'd0);
          i_rst    = 1'b0;
          exp_sent = 0;
          $display("[TB] frame aborted by reset after %0d payload bytes", i);
          break;
        end
      end
    end
    i_pl_valid = 1'b0;
    i_pl_last  = 1'b0;
    if (cyc >= 20000) check("beat_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    @(negedge i_clk);
    while ((o_busy || mon_busy || !i_tx_ready) && c < 5000) begin
      c++;
      @(negedge i_clk);
    end
    if (c >= 5000) check("idle_timeout", 64'd1, 64'd0);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin : main
    i_rst      = 1'b1;
    i_pl_valid = 1'b0;
    i_pl_data  = 8'h00;
    i_pl_last  = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_outs", 64'(w_outs), 64'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("idle_outs", 64'(w_outs), 64'd0);

    send_frame(1, 0, -1, 'hA5, 1'b0);
    wait_idle();
    send_frame(46, 0, -1, 0, 1'b0);
    wait_idle();
    send_frame(1486, 30, -1, 0, 1'b1);
    wait_idle();
    send_frame(1487, 0, -1, 0, 1'b1);
    wait_idle();
    check("sent_after_drop1", 64'(o_frames_sent), 64'd3);
    send_frame(1490, 20, -1, 0, 1'b1);
    wait_idle();
    check("sent_after_drop2", 64'(o_frames_sent), 64'd3);
    tx_delay = 5;
    send_frame(20, 0, -1, 'h40, 1'b0);
    wait_idle();
    tx_delay = 2;
    send_frame(30, 0, 20, 'h80, 1'b0);
    wait_idle();
    send_frame(10, 10, -1, 'hC0, 1'b0);
    wait_idle();

    check("final_frames_sent", 64'(o_frames_sent), 64'd1);
    check("err_count", 64'(n_err), 64'd2);
    check("tx_requests", 64'(tx_rises), 64'd5);
    check("writes_past_max", 64'(wr_hi), 64'd0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
